apb_fifo_regs: RTL and testbench

//  APB4 completer (slave) that terminates the bus driven through the team's APB interface
//  (DUT modport) and fronts an internal synchronous data FIFO via a small register map.

---
 rtl/apb_fifo_regs.sv | 186 ++++++++++++++++++
 tb/tb_apb_fifo_regs.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_regs.sv
// APB4 completer fronting a synchronous data FIFO through a five-register map.
// Programmable wait states, byte-masked control writes, error responses and a fill-level interrupt.
module apb_fifo_regs #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic [31:0] PADDR,
   input  logic [2:0]  PPROT,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  PSTRB,
   output logic        PREADY,
   output logic [31:0] PRDATA,
   output logic        PSLVERR,
   output logic        irq
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned TW = 9;

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_DWR    = 3'd2;
   localparam logic [2:0] OFF_DRD    = 3'd3;
   localparam logic [2:0] OFF_THRESH = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [WW-1:0] wcnt_q;
   logic [WW-1:0] wcnt_d;

   logic          en_q;
   logic [TW-1:0] thresh_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [DW-1:0] mem [DEPTH];

   logic [2:0]    off;
   logic          full;
   logic          empty;
   logic          err;
   logic [DW-1:0] rdata;
   logic          wr_ok;
   logic          rd_ok;
   logic          push;
   logic          pop;
   logic          ctrl_wr;
   logic          flush;
   logic          thresh_wr;
   logic          unused_bits;

   assign unused_bits = ^{PPROT, PADDR[31:5], PADDR[1:0]};

   assign off   = PADDR[4:2];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Transfer tracking state and wait-state counter
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // PREADY is only ever raised while the completer is still selected
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      PREADY  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (PSEL && !PENABLE) state_d = ST_SETUP;
         end
         ST_SETUP: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACCESS;
               wcnt_d  = WW'(WAIT_STATES);
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
            end else if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - 1'b1;
            end else begin
               PREADY  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Address decode, access legality and read mux
   always_comb begin
      err   = 1'b0;
      rdata = '0;
      case (off)
         OFF_CTRL: begin
            rdata = {31'b0, en_q};
         end
         OFF_STATUS: begin
            err   = PWRITE;
            rdata = {7'b0, TW'(count_q), 14'b0, full, empty};
         end
         OFF_DWR: begin
            err = !PWRITE || (PSTRB != 4'hF) || full || !en_q;
         end
         OFF_DRD: begin
            err   = PWRITE || empty || !en_q;
            rdata = mem[rd_ptr_q];
         end
         OFF_THRESH: begin
            rdata = {23'b0, thresh_q};
         end
         default: err = 1'b1;
      endcase
   end

   assign wr_ok     = PREADY && PWRITE && !err;
   assign rd_ok     = PREADY && !PWRITE && !err;
   assign push      = wr_ok && (off == OFF_DWR);
   assign pop       = rd_ok && (off == OFF_DRD);
   assign ctrl_wr   = wr_ok && (off == OFF_CTRL) && PSTRB[0];
   assign flush     = ctrl_wr && PWDATA[1];
   assign thresh_wr = wr_ok && (off == OFF_THRESH);

   assign PRDATA  = rd_ok ? rdata : '0;
   assign PSLVERR = PREADY && err;

   // Control registers, FIFO pointers and the registered interrupt
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         en_q     <= 1'b0;
         thresh_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         irq      <= 1'b0;
      end else begin
         if (ctrl_wr) en_q <= PWDATA[0];
         if (thresh_wr) begin
            if (PSTRB[0]) thresh_q[7:0] <= PWDATA[7:0];
            if (PSTRB[1]) thresh_q[8]   <= PWDATA[8];
         end
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q  <= count_q + 1'b1;
         end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
         end
         irq <= en_q && (thresh_q != '0) && (TW'(count_q) >= thresh_q);
      end
   end

   // Storage array needs no reset; occupancy is tracked by count_q
   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr_q] <= PWDATA;
   end

endmodule

// File: tb/tb_apb_fifo_regs.sv
// Directed bench for apb_fifo_regs: the bus driver queues each expected response and a
// negedge monitor compares it against PRDATA/PSLVERR whenever PREADY is seen high.
`timescale 1ns/1ps
module tb_apb_fifo_regs;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WS    = 2;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [31:0] PADDR;
   logic [2:0]  PPROT;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERR;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q [$];
   string       name_q [$];
   logic [32:0] mon_e;
   string       mon_n;

   apb_fifo_regs #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%09h required=0x%09h", nm, act, exp);
      end
   endtask

   // Response monitor: {PSLVERR, PRDATA} against the oldest queued expectation
   always @(negedge PCLK) begin
      if (PRESETn === 1'b1 && PREADY === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready actual=0x%09h required=none", {PSLVERR, PRDATA});
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            check(mon_n, {PSLVERR, PRDATA}, mon_e);
         end
      end
   end

   // Called at cycle start (just after a rising edge); returns at the cycle start after completion
   task automatic xfer(input string nm, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee);
      int lowc;
      bit done;
      exp_q.push_back({ee, er});
      name_q.push_back(nm);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      lowc = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge PCLK);
         if (PREADY === 1'b1) done = 1'b1;
         else lowc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_pready required=pready", nm);
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end else begin
         // One completer SETUP cycle plus WS counted ACCESS cycles precede completion
         check({nm, "_wait"}, 33'(lowc), 33'(WS + 1));
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic ee);
      xfer(nm, a, 1'b1, d, s, 32'h0, ee);
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] er, input logic ee);
      xfer(nm, a, 1'b0, 32'h0, 4'h0, er, ee);
   endtask

   task automatic sync();
      @(posedge PCLK); #1;
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESETn = 1'b0; PADDR = '0; PPROT = '0; PSEL = 1'b0; PENABLE = 1'b0;
      PWRITE = 1'b0; PWDATA = '0; PSTRB = '0;

      // T1 reset
      repeat (3) @(negedge PCLK);
      check("reset_outs", {PREADY, PSLVERR, irq, PRDATA[29:0]}, 33'h0);
      check("reset_prdata", 33'(PRDATA), 33'h0);
      sync();
      PRESETn = 1'b1;
      sync();
      rd("t1_status", 32'h04, 32'h0000_0001, 1'b0);

      // T2 push/pop, back-to-back transfers
      wr("t2_ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
      wr("t2_push0", 32'h08, 32'hA5A5_0001, 4'hF, 1'b0);
      wr("t2_push1", 32'h08, 32'h0000_0002, 4'hF, 1'b0);
      rd("t2_pop0", 32'h0C, 32'hA5A5_0001, 1'b0);
      rd("t2_pop1", 32'h0C, 32'h0000_0002, 1'b0);
      rd("t2_status", 32'h04, 32'h0000_0001, 1'b0);
      rd("t2_ctrl_rd", 32'h00, 32'h0000_0001, 1'b0);

      // T3 full/empty boundaries
      for (int i = 0; i < DEPTH; i++) wr("t3_push", 32'h08, 32'h100 + 32'(i), 4'hF, 1'b0);
      rd("t3_status_full", 32'h04, 32'h0010_0002, 1'b0);
      wr("t3_push_full", 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b1);
      rd("t3_status_still_full", 32'h04, 32'h0010_0002, 1'b0);
      for (int i = 0; i < DEPTH; i++) rd("t3_pop", 32'h0C, 32'h100 + 32'(i), 1'b0);
      rd("t3_pop_empty", 32'h0C, 32'h0, 1'b1);
      rd("t3_status_empty", 32'h04, 32'h0000_0001, 1'b0);

      // T5 strobes and error responses
      wr("t5_push", 32'h08, 32'h0000_0077, 4'hF, 1'b0);
      wr("t5_ctrl_nostrb", 32'h00, 32'h3, 4'h0, 1'b0);
      rd("t5_ctrl_kept", 32'h00, 32'h1, 1'b0);
      wr("t5_push_strb7", 32'h08, 32'h1234_5678, 4'h7, 1'b1);
      rd("t5_status_one", 32'h04, 32'h0001_0000, 1'b0);
      rd("t5_unmapped", 32'h14, 32'h0, 1'b1);
      wr("t5_wr_status", 32'h04, 32'hFFFF_FFFF, 4'hF, 1'b1);
      wr("t5_wr_datard", 32'h0C, 32'h1, 4'hF, 1'b1);
      rd("t5_rd_datawr", 32'h08, 32'h0, 1'b1);
      wr("t5_flush", 32'h00, 32'h3, 4'hF, 1'b0);
      rd("t5_status_flushed", 32'h04, 32'h0000_0001, 1'b0);
      rd("t5_ctrl_after_flush", 32'h00, 32'h1, 1'b0);

      // T6 threshold interrupt, one cycle behind count
      wr("t6_thresh", 32'h10, 32'h4, 4'hF, 1'b0);
      rd("t6_thresh_rd", 32'h10, 32'h4, 1'b0);
      for (int i = 0; i < 3; i++) wr("t6_push", 32'h08, 32'h200 + 32'(i), 4'hF, 1'b0);
      @(negedge PCLK);
      check("t6_irq_below", 33'(irq), 33'h0);
      sync();
      wr("t6_push4", 32'h08, 32'h203, 4'hF, 1'b0);
      @(negedge PCLK);
      check("t6_irq_latency", 33'(irq), 33'h0);
      @(negedge PCLK);
      check("t6_irq_set", 33'(irq), 33'h1);
      sync();
      wr("t6_flush", 32'h00, 32'h3, 4'hF, 1'b0);
      @(negedge PCLK);
      check("t6_irq_hold", 33'(irq), 33'h1);
      @(negedge PCLK);
      check("t6_irq_drop", 33'(irq), 33'h0);
      sync();
      rd("t6_status_flushed", 32'h04, 32'h0000_0001, 1'b0);
      wr("t6_thresh_hi", 32'h10, 32'h1FF, 4'h2, 1'b0);
      rd("t6_thresh_masked", 32'h10, 32'h104, 1'b0);

      // PSEL dropped mid-ACCESS: no completion, no side effect
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h00; PWRITE = 1'b1; PWDATA = 32'h0; PSTRB = 4'hF;
      sync();
      PENABLE = 1'b1;
      sync();
      PSEL = 1'b0; PENABLE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge PCLK);
         check("drop_pready", 33'(PREADY), 33'h0);
      end
      sync();
      rd("drop_ctrl_kept", 32'h00, 32'h1, 1'b0);

      // Reset during the ACCESS phase of a push
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h08; PWRITE = 1'b1; PWDATA = 32'hCAFE_0001; PSTRB = 4'hF;
      sync();
      PENABLE = 1'b1;
      sync();
      PRESETn = 1'b0;
      @(negedge PCLK);
      check("abort_outs", {PREADY, PSLVERR, irq, PRDATA[29:0]}, 33'h0);
      sync();
      PSEL = 1'b0; PENABLE = 1'b0;
      sync();
      PRESETn = 1'b1;
      sync();
      rd("abort_status", 32'h04, 32'h0000_0001, 1'b0);
      rd("abort_ctrl", 32'h00, 32'h0, 1'b0);
      rd("abort_thresh", 32'h10, 32'h0, 1'b0);
      wr("abort_push_disabled", 32'h08, 32'h1, 4'hF, 1'b1);
      rd("abort_pop_disabled", 32'h0C, 32'h0, 1'b1);

      repeat (3) @(posedge PCLK);
      check("scoreboard_drained", 33'(exp_q.size()), 33'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
